memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/memory_access_stage_pkg.sv | 21 ++
 rtl/memory_access_stage_mem_wait_counter.sv | 49 ++++
 rtl/memory_access_stage.sv | 191 +++++++++++++++++++
 tb/tb_memory_access_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// ----------------------------------------------------------------------------
// memory_access_stage_pkg
// Shared definitions for the memory access pipeline stage:
//   - default data/address width and access timeout
//   - wait-counter and register-index widths
//   - FSM state encoding (2 bits)
// ----------------------------------------------------------------------------
package memory_access_stage_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned MAX_WAIT_DEF = 15;
  localparam int unsigned WAIT_CNT_W   = 4;
  localparam int unsigned REG_IDX_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } mas_state_e;

endpackage

// File: rtl/memory_access_stage_mem_wait_counter.sv
// ----------------------------------------------------------------------------
// mem_wait_counter
// 4-bit counter of ACCESS cycles spent without dmem_ready.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset (count -> 0)
//   clr_i  synchronous clear, has priority over en_i
//   en_i   count one more wait cycle
//   tc_o   terminal count: the current cycle is the MAX_WAIT-th wait cycle
// ----------------------------------------------------------------------------
module mem_wait_counter
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WAIT_CNT_W-1:0] TC_VAL = WAIT_CNT_W'(MAX_WAIT - 1);

  logic [WAIT_CNT_W-1:0] count_q;
  logic [WAIT_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of earlier wait cycles, so the MAX_WAIT-th
  // cycle without ready is the one where count_q == MAX_WAIT-1.
  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/memory_access_stage.sv
// ----------------------------------------------------------------------------
// memory_access_stage
// Pipeline MEM stage: issues one data-memory access per load/store taken
// from the EX/MEM register, waits for dmem_ready (bounded by MAX_WAIT),
// returns load data and a one-cycle completion pulse, and freezes upstream
// stages while the access is outstanding.
//
// Optional feature macro: MEM_FWD_EN
//   defined   : store data forwarded from the writeback stage on a match
//   undefined : store data is always reg2_xm (rt_xm / *_wb unused)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_read_xm/mem_write_xm load / store request (write wins if both)
//   hlt_xm                   halt: blocks acceptance of a new op in IDLE
//   alu_out                  byte address (bit 0 set -> misaligned)
//   reg2_xm, rt_xm           store data and its source register
//   reg_write_wb, write_reg_wb, write_data_wb  writeback-stage result
//   dmem_*                   data memory request interface
//   mem_data_out             load result (0 after misalign/timeout)
//   mem_valid                one-cycle completion pulse
//   stall_mem                freeze upstream while op is pending
//   err_misalign/err_timeout sticky error flags, cleared by rst only
// ----------------------------------------------------------------------------
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read_xm,
  input  logic                 mem_write_xm,
  input  logic                 hlt_xm,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic [DATA_W-1:0]    reg2_xm,
  input  logic [REG_IDX_W-1:0] rt_xm,
  input  logic                 reg_write_wb,
  input  logic [REG_IDX_W-1:0] write_reg_wb,
  input  logic [DATA_W-1:0]    write_data_wb,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [DATA_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]    dmem_wdata,
  input  logic [DATA_W-1:0]    dmem_rdata,
  input  logic                 dmem_ready,
  output logic [DATA_W-1:0]    mem_data_out,
  output logic                 mem_valid,
  output logic                 stall_mem,
  output logic                 err_misalign,
  output logic                 err_timeout
);

  mas_state_e        state_q,   state_d;
  logic              req_q,     req_d;
  logic              we_q,      we_d;
  logic              is_load_q, is_load_d;
  logic [DATA_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              valid_q,   valid_d;
  logic              emis_q,    emis_d;
  logic              eto_q,     eto_d;

  logic              op;
  logic              wait_tc;
  logic [DATA_W-1:0] store_data;

  assign op = (mem_read_xm | mem_write_xm) & ~hlt_xm;

`ifdef MEM_FWD_EN
  logic fwd_hit;
  // Register 0 is never a real forwarding source.
  assign fwd_hit    = mem_write_xm & reg_write_wb &
                      (write_reg_wb == rt_xm) & (write_reg_wb != '0);
  assign store_data = fwd_hit ? write_data_wb : reg2_xm;
`else
  logic unused_fwd;
  assign store_data = reg2_xm;
  assign unused_fwd = ^{rt_xm, reg_write_wb, write_reg_wb, write_data_wb};
`endif

  mem_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (state_q != ST_ACCESS),
    .en_i  ((state_q == ST_ACCESS) & ~dmem_ready),
    .tc_o  (wait_tc)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    is_load_d = is_load_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    valid_d   = 1'b0;
    emis_d    = emis_q;
    eto_d     = eto_q;

    unique case (state_q)
      ST_IDLE: begin
        if (op) begin
          if (alu_out[0]) begin
            emis_d  = 1'b1;
            rdata_d = '0;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d    = alu_out;
            wdata_d   = store_data;
            we_d      = mem_write_xm;
            is_load_d = ~mem_write_xm;
            req_d     = 1'b1;
            state_d   = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // A ready in the last permitted cycle still completes normally.
        if (dmem_ready) begin
          if (is_load_q) begin
            rdata_d = dmem_rdata;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else if (wait_tc) begin
          eto_d   = 1'b1;
          rdata_d = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      emis_q    <= 1'b0;
      eto_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      is_load_q <= is_load_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      emis_q    <= emis_d;
      eto_q     <= eto_d;
    end
  end

  // Upstream is held from the cycle an op is presented until DONE.
  assign stall_mem    = ((state_q == ST_IDLE) & op) | (state_q == ST_ACCESS);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign mem_data_out = rdata_q;
  assign mem_valid    = valid_q;
  assign err_misalign = emis_q;
  assign err_timeout  = eto_q;

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_xm, mem_write_xm, hlt_xm;
  logic [15:0] alu_out, reg2_xm, write_data_wb, dmem_rdata;
  logic [3:0]  rt_xm, write_reg_wb;
  logic        reg_write_wb, dmem_ready;
  logic        dmem_req, dmem_we, mem_valid, stall_mem, err_misalign, err_timeout;
  logic [15:0] dmem_addr, dmem_wdata, mem_data_out;

  always #5 clk = ~clk;

  memory_access_stage #(
    .DATA_W   (16),
    .MAX_WAIT (MW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_xm   (mem_read_xm),
    .mem_write_xm  (mem_write_xm),
    .hlt_xm        (hlt_xm),
    .alu_out       (alu_out),
    .reg2_xm       (reg2_xm),
    .rt_xm         (rt_xm),
    .reg_write_wb  (reg_write_wb),
    .write_reg_wb  (write_reg_wb),
    .write_data_wb (write_data_wb),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .mem_data_out  (mem_data_out),
    .mem_valid     (mem_valid),
    .stall_mem     (stall_mem),
    .err_misalign  (err_misalign),
    .err_timeout   (err_timeout)
  );

  typedef struct packed {
    logic        stall, req, we, valid, emis, eto;
    logic [15:0] addr, wdata, data;
  } exp_t;

  exp_t        ex;
  bit          ex_on = 1'b0;
  int          total = 0;
  int          bad   = 0;
  int          req_cnt, stall_cnt, valid_cnt, we_cnt;
  logic [15:0] seen_wdata;

  // Transaction-level model state: last result and sticky flags.
  logic [15:0] m_data;
  logic        m_emis, m_eto;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic stall, req, we, valid,
                              input logic [15:0] addr, wdata);
    exp_t e;
    e.stall = stall; e.req = req; e.we = we; e.valid = valid;
    e.addr = addr; e.wdata = wdata;
    e.data = m_data; e.emis = m_emis; e.eto = m_eto;
    return e;
  endfunction

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    if (ex_on) begin
      chk("stall_mem",    16'(stall_mem),    16'(ex.stall));
      chk("dmem_req",     16'(dmem_req),     16'(ex.req));
      chk("dmem_we",      16'(dmem_we),      16'(ex.we));
      chk("mem_valid",    16'(mem_valid),    16'(ex.valid));
      chk("err_misalign", 16'(err_misalign), 16'(ex.emis));
      chk("err_timeout",  16'(err_timeout),  16'(ex.eto));
      chk("mem_data_out", mem_data_out,      ex.data);
      if (ex.req) chk("dmem_addr",  dmem_addr,  ex.addr);
      if (ex.we)  chk("dmem_wdata", dmem_wdata, ex.wdata);
      if (dmem_req === 1'b1)  req_cnt++;
      if (stall_mem === 1'b1) stall_cnt++;
      if (mem_valid === 1'b1) valid_cnt++;
      if (dmem_we === 1'b1) begin we_cnt++; seen_wdata = dmem_wdata; end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    mem_read_xm = 1'b0; mem_write_xm = 1'b0; hlt_xm = 1'b0;
    alu_out = 16'h7777; reg2_xm = 16'h3333; rt_xm = 4'd5;
    reg_write_wb = 1'b0; write_reg_wb = 4'd0; write_data_wb = 16'h0;
    dmem_ready = 1'b0; dmem_rdata = 16'hDEAD;
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) begin
      ex = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      step();
    end
  endtask

  // ready_at: ACCESS cycle (1..) in which dmem_ready is raised; 0 = never.
  task automatic run_op(input logic rd, wr, hlt,
                        input logic [15:0] addr, reg2,
                        input logic [3:0] rt, input logic rw_wb,
                        input logic [3:0] wr_wb, input logic [15:0] wd_wb,
                        input int ready_at, input logic [15:0] rdata);
    logic [15:0] sd;
    logic        op;
    bit          ok;
    int          len;
    op = (rd | wr) & ~hlt;
    sd = reg2;
`ifdef MEM_FWD_EN
    if (wr && rw_wb && wr_wb == rt && wr_wb != 4'd0) sd = wd_wb;
`endif
    req_cnt = 0; stall_cnt = 0; valid_cnt = 0; we_cnt = 0;
    mem_read_xm = rd; mem_write_xm = wr; hlt_xm = hlt;
    alu_out = addr; reg2_xm = reg2; rt_xm = rt;
    reg_write_wb = rw_wb; write_reg_wb = wr_wb; write_data_wb = wd_wb;
    dmem_ready = 1'b0; dmem_rdata = 16'hDEAD;
    ex = mk(op, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step();
    if (!op) return;
    // Inputs past acceptance must be ignored: scramble them.
    alu_out = ~addr; reg2_xm = ~reg2; write_data_wb = ~wd_wb;
    if (addr[0]) begin
      m_emis = 1'b1; m_data = 16'h0;
      ex = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
      step();
      return;
    end
    ok  = (ready_at >= 1) && (ready_at <= MW);
    len = ok ? ready_at : MW;
    for (int c = 1; c <= len; c++) begin
      hlt_xm     = (c % 2 == 1);
      dmem_ready = ok && (c == len);
      dmem_rdata = (ok && c == len) ? rdata : 16'hDEAD;
      ex = mk(1'b1, 1'b1, wr, 1'b0, addr, sd);
      step();
    end
    if (ok) begin
      if (!wr) m_data = rdata;
    end else begin
      m_eto = 1'b1; m_data = 16'h0;
    end
    dmem_ready = 1'b0; dmem_rdata = 16'hDEAD; hlt_xm = 1'b0;
    ex = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    m_data = 16'h0; m_emis = 1'b0; m_eto = 1'b0;
    step();
    ex = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    ex_on = 1'b1;
    step();
    rst = 1'b0;
    idle(2);

    // Load, ready in 2nd ACCESS cycle.
    run_op(1, 0, 0, 16'h0010, 16'h0000, 4'd0, 0, 4'd0, 16'h0, 2, 16'hBEEF);
    chk("t_load_req_cycles",   16'(req_cnt),   16'd2);
    chk("t_load_stall_cycles", 16'(stall_cnt), 16'd3);
    chk("t_load_valid_pulses", 16'(valid_cnt), 16'd1);
    chk("t_load_data",         mem_data_out,   16'hBEEF);
    idle(1);

    // Store, ready immediately.
    run_op(0, 1, 0, 16'h0020, 16'h1234, 4'd0, 0, 4'd0, 16'h0, 1, 16'hFFFF);
    chk("t_store_we_cycles",  16'(we_cnt),     16'd1);
    chk("t_store_wdata",      seen_wdata,      16'h1234);
    chk("t_store_latency",    16'(stall_cnt),  16'd2);
    chk("t_store_data_hold",  mem_data_out,    16'hBEEF);
    idle(1);

    // Misaligned load.
    run_op(1, 0, 0, 16'h0011, 16'h0000, 4'd0, 0, 4'd0, 16'h0, 1, 16'h0);
    chk("t_mis_req_cycles", 16'(req_cnt),     16'd0);
    chk("t_mis_flag",       16'(err_misalign), 16'd1);
    chk("t_mis_valid",      16'(valid_cnt),   16'd1);
    chk("t_mis_data",       mem_data_out,     16'h0000);
    idle(1);

    // Read and write together: write wins, data untouched.
    run_op(1, 1, 0, 16'h0040, 16'h5A5A, 4'd0, 0, 4'd0, 16'h0, 3, 16'hFFFF);
    chk("t_rw_we_cycles", 16'(we_cnt),  16'd3);
    chk("t_rw_data",      mem_data_out, 16'h0000);
    idle(1);

    run_op(1, 0, 0, 16'h0100, 16'h0000, 4'd0, 0, 4'd0, 16'h0, 1, 16'h1357);
    idle(1);

    // Halted op: nothing accepted.
    run_op(1, 0, 1, 16'h0200, 16'h0000, 4'd0, 0, 4'd0, 16'h0, 1, 16'h0);
    chk("t_hlt_stall", 16'(stall_cnt), 16'd0);
    idle(2);
    chk("t_hlt_data",  mem_data_out,   16'h1357);

    // Timeout.
    run_op(1, 0, 0, 16'h0400, 16'h0000, 4'd0, 0, 4'd0, 16'h0, 0, 16'h0);
    chk("t_to_req_cycles", 16'(req_cnt),    16'd15);
    chk("t_to_flag",       16'(err_timeout), 16'd1);
    chk("t_to_data",       mem_data_out,    16'h0000);
    idle(1);

    // Ready in the last permitted cycle still completes.
    run_op(1, 0, 0, 16'h0402, 16'h0000, 4'd0, 0, 4'd0, 16'h0, 15, 16'h2468);
    chk("t_last_req_cycles", 16'(req_cnt), 16'd15);
    chk("t_last_data",       mem_data_out, 16'h2468);
    idle(1);

    // Forwarding from writeback.
    run_op(0, 1, 0, 16'h0030, 16'h0001, 4'd3, 1, 4'd3, 16'hAAAA, 1, 16'h0);
`ifdef MEM_FWD_EN
    chk("t_fwd_hit_wdata", seen_wdata, 16'hAAAA);
`else
    chk("t_fwd_hit_wdata", seen_wdata, 16'h0001);
`endif
    idle(1);
    run_op(0, 1, 0, 16'h0030, 16'h0001, 4'd3, 1, 4'd0, 16'hAAAA, 1, 16'h0);
    chk("t_fwd_r0_wdata", seen_wdata, 16'h0001);
    idle(1);

    // Reset during ACCESS.
    valid_cnt = 0;
    mem_read_xm = 1'b1; alu_out = 16'h0200;
    ex = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    step();
    ex = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0);
    step();
    rst = 1'b1;
    ex = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0);
    step();
    rst = 1'b0;
    m_data = 16'h0; m_emis = 1'b0; m_eto = 1'b0;
    idle(3);
    chk("t_rst_no_valid", 16'(valid_cnt),   16'd0);
    chk("t_rst_emis",     16'(err_misalign), 16'd0);
    chk("t_rst_eto",      16'(err_timeout),  16'd0);

    run_op(1, 0, 0, 16'h0300, 16'h0000, 4'd0, 0, 4'd0, 16'h0, 2, 16'h0F0F);
    chk("t_post_rst_data", mem_data_out, 16'h0F0F);
    idle(2);

    ex_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
